// File: rtl/fetch_pkg.sv
// Shared widths, return-buffer depth and FSM state encoding for the address-fetch block.
package fetch_pkg;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Return-data buffer: synchronous FIFO, head visible combinationally on pop_data.
// Push when full is accepted only alongside a pop; pop when empty is ignored.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int W     = DATA_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/addr_fetch.sv
// Issues one read per accepted address to a 1-cycle synchronous memory and returns data in order.
// Address intake stalls once buffered + in-flight words reach FIFO_DEPTH; ADDR_FETCH_PERF_EN adds stall_cycles.
module addr_fetch
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       num_elems,
  input  logic [ADDR_W-1:0] addr,
  input  logic              addr_valid,
  output logic              addr_ready,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
`ifdef ADDR_FETCH_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);
  fetch_state_t     state;
  fetch_state_t     state_nxt;
  logic [31:0]      num_q;
  logic [31:0]      issued;
  logic             inflight;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] occupancy;
  logic             fifo_pop;
  logic             start_ok;

  assign occupancy = fifo_count + CNT_W'(inflight);
  assign start_ok  = (state == IDLE) && start;

  always_comb begin
    state_nxt  = state;
    addr_ready = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = (num_elems == '0) ? DONE : RUN;
      RUN: begin
        // Reserve a slot for the word still in flight so a return is never dropped.
        addr_ready = (issued < num_q) && (occupancy < CNT_W'(FIFO_DEPTH)) && !fifo_full;
        if (issued == num_q) state_nxt = DRAIN;
      end
      DRAIN: if (fifo_empty && !inflight) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst) addr_ready = 1'b0;
  end

  assign mem_en    = addr_valid && addr_ready;
  assign mem_addr  = addr;
  assign out_valid = !fifo_empty && !rst;
  assign fifo_pop  = out_valid && out_ready;
  assign busy      = (state != IDLE) && !rst;
  assign done      = (state == DONE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      num_q    <= '0;
      issued   <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= mem_en;
      if (start_ok) begin
        num_q  <= num_elems;
        issued <= '0;
      end else if (mem_en) begin
        issued <= issued + 32'd1;
      end
    end
  end

  fetch_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (mem_rdata),
    .pop       (fifo_pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef ADDR_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      stall_cycles <= '0;
    end else if ((state == RUN) && addr_valid && !addr_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_addr_fetch.sv
// Directed bench for addr_fetch: table of transfers plus hand sequences for reset and empty transfers.
module tb_addr_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] num_elems;
  logic [31:0] addr;
  logic        addr_valid;
  logic        addr_ready;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
`ifdef ADDR_FETCH_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  addr_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_elems  (num_elems),
    .addr       (addr),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
`ifdef ADDR_FETCH_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // Synchronous-read memory: word at address A reads back as A+1.
  always @(posedge clk) mem_rdata <= mem_en ? (mem_addr + 32'd1) : 32'hBAD0_BAD0;

  typedef struct {
    int          n;
    logic [31:0] a [8];
    logic [31:0] d [8];
    int          hold;
    int          exp_men_hold;
    bit          repulse;
    int          exp_stall;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_xfer(input vec_t v, input string tag);
    int   ai = 0;
    int   oi = 0;
    int   men = 0;
    int   dcnt = 0;
    int   acc_hold = 0;
    bit   seen_done = 0;
    bit   stalled = 0;
    bit   fin = 0;
    logic [31:0] prev_d = '0;
    @(negedge clk);
    start = 1'b1;
    num_elems = v.n;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      addr_valid = (ai < v.n);
      if (ai < v.n) addr = v.a[ai];
      else addr = 32'd0;
      out_ready = (cyc >= v.hold);
      start = v.repulse && (cyc == 1);
      if (start) num_elems = 32'd20;
      #1;
      if (seen_done) begin
        chk({tag, " busy_after_done"}, 32'(busy), 32'd0);
        chk({tag, " done_width"}, 32'(done), 32'd0);
        fin = 1;
      end else begin
        chk({tag, " mem_en_vs_handshake"}, 32'(mem_en), 32'(addr_valid && addr_ready));
        if (mem_en) begin
          men++;
          chk({tag, " mem_addr"}, mem_addr, addr);
        end
        if (addr_valid && addr_ready) begin
          ai++;
          if (cyc < v.hold) acc_hold++;
        end
        if (stalled) chk({tag, " out_data_hold"}, out_data, prev_d);
        stalled = out_valid && !out_ready;
        prev_d  = out_data;
        if (out_valid && out_ready) begin
          if (oi < v.n) chk({tag, " out_data"}, out_data, v.d[oi]);
          else chk({tag, " extra_output"}, 32'(oi), 32'(v.n));
          oi++;
        end
        if (v.hold > 0 && cyc == v.hold - 1) begin
          chk({tag, " mem_en_during_hold"}, 32'(men), 32'(v.exp_men_hold));
          chk({tag, " addr_ready_full"}, 32'(addr_ready), 32'd0);
        end
`ifdef ADDR_FETCH_PERF_EN
        if (v.exp_stall >= 0) begin
          if (cyc == 0) chk({tag, " stall_clear"}, stall_cycles, 32'd0);
          if (cyc == v.hold) begin
            chk({tag, " stall_hand"}, stall_cycles, 32'(v.exp_stall));
            chk({tag, " stall_model"}, stall_cycles, 32'(v.hold - acc_hold));
          end
        end
`endif
        if (done) begin
          dcnt++;
          chk({tag, " busy_with_done"}, 32'(busy), 32'd1);
          seen_done = 1;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    addr_valid = 1'b0;
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: got no completion expected done within 300 cycles", tag);
    end
    chk({tag, " outputs"}, 32'(oi), 32'(v.n));
    chk({tag, " mem_en_total"}, 32'(men), 32'(v.n));
    chk({tag, " done_pulses"}, 32'(dcnt), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    vt[0].n = 6; vt[0].hold = 0; vt[0].exp_men_hold = 0; vt[0].repulse = 0; vt[0].exp_stall = -1;
    vt[0].a = '{32'd0, 32'd4, 32'd8, 32'd100, 32'd104, 32'd108, 32'd0, 32'd0};
    vt[0].d = '{32'd1, 32'd5, 32'd9, 32'd101, 32'd105, 32'd109, 32'd0, 32'd0};
    vt[1].n = 8; vt[1].hold = 10; vt[1].exp_men_hold = 4; vt[1].repulse = 0; vt[1].exp_stall = 6;
    vt[1].a = '{32'd16, 32'd32, 32'd48, 32'd64, 32'd80, 32'd96, 32'd112, 32'd128};
    vt[1].d = '{32'd17, 32'd33, 32'd49, 32'd65, 32'd81, 32'd97, 32'd113, 32'd129};
    vt[2].n = 2; vt[2].hold = 0; vt[2].exp_men_hold = 0; vt[2].repulse = 0; vt[2].exp_stall = -1;
    vt[2].a = '{32'h1000, 32'h2000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vt[2].d = '{32'h1001, 32'h2001, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vt[3].n = 3; vt[3].hold = 0; vt[3].exp_men_hold = 0; vt[3].repulse = 1; vt[3].exp_stall = -1;
    vt[3].a = '{32'd7, 32'd9, 32'd11, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vt[3].d = '{32'd8, 32'd10, 32'd12, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vt[4].n = 1; vt[4].hold = 0; vt[4].exp_men_hold = 0; vt[4].repulse = 0; vt[4].exp_stall = -1;
    vt[4].a = '{32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vt[4].d = '{32'hFFFF_FFF1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

    rst = 1'b1; start = 1'b0; num_elems = '0; addr = '0; addr_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst addr_ready", 32'(addr_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst busy", 32'(busy), 32'd0);
    chk("post_rst mem_en", 32'(mem_en), 32'd0);
`ifdef ADDR_FETCH_PERF_EN
    chk("post_rst stall", stall_cycles, 32'd0);
`endif

    // Zero-length transfer: straight to DONE, no memory traffic.
    @(negedge clk);
    start = 1'b1; num_elems = 32'd0; addr_valid = 1'b1; addr = 32'd5;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("zero done", 32'(done), 32'd1);
    chk("zero mem_en", 32'(mem_en), 32'd0);
    chk("zero out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("zero done_after", 32'(done), 32'd0);
    chk("zero busy_after", 32'(busy), 32'd0);
    chk("zero mem_en_after", 32'(mem_en), 32'd0);
    addr_valid = 1'b0;

    for (int k = 0; k < 5; k++) run_xfer(vt[k], $sformatf("vec%0d", k));

    // Reset mid-transfer, with a coincident start that reset must override.
    @(negedge clk);
    start = 1'b1; num_elems = 32'd10; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    acc = 0;
    for (int c = 0; c < 50 && acc < 3; c++) begin
      addr_valid = 1'b1;
      addr = 32'h40 + 32'(acc) * 32'd4;
      #1;
      if (addr_ready) acc++;
      @(negedge clk);
    end
    chk("midrst accepted", 32'(acc), 32'd3);
    rst = 1'b1; start = 1'b1; num_elems = 32'd5; addr_valid = 1'b1;
    #1;
    chk("midrst mem_en_in_rst", 32'(mem_en), 32'd0);
    chk("midrst out_valid_in_rst", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0; addr_valid = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst addr_ready", 32'(addr_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("midrst late_rdata_dropped", 32'(out_valid), 32'd0);
    run_xfer(vt[2], "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
